// File: rtl/trivium_pkg.sv
// Shared constants, tap positions and FSM encoding for the Trivium block generator.
package trivium_pkg;

    localparam int STATE_W    = 288;
    localparam int KEY_W      = 80;
    localparam int IV_W       = 80;
    localparam int INIT_STEPS = 1152;

    localparam int TAP_66  = 66;
    localparam int TAP_93  = 93;
    localparam int TAP_91  = 91;
    localparam int TAP_92  = 92;
    localparam int TAP_171 = 171;
    localparam int TAP_162 = 162;
    localparam int TAP_177 = 177;
    localparam int TAP_175 = 175;
    localparam int TAP_176 = 176;
    localparam int TAP_264 = 264;
    localparam int TAP_243 = 243;
    localparam int TAP_288 = 288;
    localparam int TAP_286 = 286;
    localparam int TAP_287 = 287;
    localparam int TAP_69  = 69;

    typedef enum logic [1:0] {
        LOAD,
        WARMUP,
        GEN,
        DONE
    } gen_state_e;

    // Bit i of the vector holds s(i+1); key/iv MSB lands in s1 / s94.
    function automatic logic [STATE_W-1:0] load_state(
        input logic [KEY_W-1:0] key,
        input logic [IV_W-1:0]  iv
    );
        logic [STATE_W-1:0] s;
        s = '0;
        for (int i = 0; i < KEY_W; i++) begin
            s[i]      = key[KEY_W-1-i];
            s[93 + i] = iv[IV_W-1-i];
        end
        s[STATE_W-1 -: 3] = 3'b111;
        return s;
    endfunction

endpackage

// File: rtl/trivium_block_gen_if.sv
// Controller <-> block generator bundle: key/iv/next_block in, end_o/block_o out.
interface trivium_block_gen_if #(
    parameter int BLOCK_W = 64
);
    import trivium_pkg::*;

    logic [KEY_W-1:0]   key;
    logic [IV_W-1:0]    iv;
    logic               next_block;
    logic               end_o;
    logic [BLOCK_W-1:0] block_o;

    modport master (
        output key, iv, next_block,
        input  end_o, block_o
    );

    modport slave (
        input  key, iv, next_block,
        output end_o, block_o
    );

endinterface

// File: rtl/trivium_step.sv
// One combinational Trivium step: next 288-bit state plus keystream bit z.
module trivium_step
    import trivium_pkg::*;
(
    input  logic [STATE_W-1:0] cur,
    output logic [STATE_W-1:0] nxt,
    output logic               z
);

    logic t1, t2, t3;
    logic a1, a2, a3;

    always_comb begin
        a1 = cur[TAP_66-1]  ^ cur[TAP_93-1];
        a2 = cur[TAP_162-1] ^ cur[TAP_177-1];
        a3 = cur[TAP_243-1] ^ cur[TAP_288-1];
        z  = a1 ^ a2 ^ a3;
        t1 = a1 ^ (cur[TAP_91-1]  & cur[TAP_92-1])  ^ cur[TAP_171-1];
        t2 = a2 ^ (cur[TAP_175-1] & cur[TAP_176-1]) ^ cur[TAP_264-1];
        t3 = a3 ^ (cur[TAP_286-1] & cur[TAP_287-1]) ^ cur[TAP_69-1];
        nxt = {cur[286:177], t2, cur[175:93], t1, cur[91:0], t3};
    end

endmodule

// File: rtl/trivium_block_gen.sv
// Trivium keystream block generator: LOAD -> WARMUP -> GEN -> DONE, 64-bit blocks.
// Optional block_count output when TRIVIUM_BLOCK_COUNT_EN is defined.
module trivium_block_gen
    import trivium_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 1,
    parameter int BLOCK_W        = 64
) (
    input  logic                clk,
    input  logic                rst,
    trivium_block_gen_if.slave  bus
`ifdef TRIVIUM_BLOCK_COUNT_EN
    ,
    output logic [31:0]         block_count
`endif
);

    localparam int B        = BITS_PER_CYCLE;
    localparam int WARM_CYC = INIT_STEPS / B;
    localparam int GEN_CYC  = BLOCK_W / B;
    localparam logic [10:0] WARM_LAST = 11'(WARM_CYC - 1);
    localparam logic [10:0] GEN_LAST  = 11'(GEN_CYC - 1);

    logic [1:0]         rst_sync;
    logic               rst_n_i;
    gen_state_e         state_q, state_d;
    logic [10:0]        cnt_q, cnt_d;
    logic [STATE_W-1:0] s_q, s_d, s_step;
    logic [BLOCK_W-1:0] sh_q, sh_d, sh_gen;
    logic [BLOCK_W-1:0] blk_q, blk_d;
    logic               end_q, end_d;
    logic [B-1:0]       zs;

    // Assertion is immediate; release reaches the core two edges later.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rst_sync <= 2'b00;
        else      rst_sync <= {rst_sync[0], 1'b1};
    end

    assign rst_n_i = rst_sync[1];

    for (genvar i = 0; i < B; i++) begin : g_step
        logic [STATE_W-1:0] cur;
        logic [STATE_W-1:0] nxt;
        if (i == 0) begin : g_first
            assign cur = s_q;
        end else begin : g_rest
            assign cur = g_step[i-1].nxt;
        end
        trivium_step u_step (
            .cur (cur),
            .nxt (nxt),
            .z   (zs[i])
        );
    end

    assign s_step = g_step[B-1].nxt;

    always_comb begin
        sh_gen = sh_q;
        for (int i = 0; i < B; i++) begin
            sh_gen = {sh_gen[BLOCK_W-2:0], zs[i]};
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        sh_d    = sh_q;
        blk_d   = blk_q;
        end_d   = end_q;
        unique case (state_q)
            LOAD: begin
                s_d     = load_state(bus.key, bus.iv);
                cnt_d   = '0;
                state_d = WARMUP;
            end
            WARMUP: begin
                s_d = s_step;
                if (cnt_q == WARM_LAST) begin
                    cnt_d   = '0;
                    state_d = GEN;
                end else begin
                    cnt_d = cnt_q + 11'd1;
                end
            end
            GEN: begin
                s_d  = s_step;
                sh_d = sh_gen;
                if (cnt_q == GEN_LAST) begin
                    cnt_d   = '0;
                    blk_d   = sh_gen;
                    end_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 11'd1;
                end
            end
            DONE: begin
                if (bus.next_block) begin
                    end_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = GEN;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= LOAD;
            cnt_q   <= '0;
            s_q     <= '0;
            sh_q    <= '0;
            blk_q   <= '0;
            end_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            sh_q    <= sh_d;
            blk_q   <= blk_d;
            end_q   <= end_d;
        end
    end

    assign bus.end_o   = end_q;
    assign bus.block_o = blk_q;

`ifdef TRIVIUM_BLOCK_COUNT_EN
    logic [31:0] blk_cnt_q;

    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            blk_cnt_q <= '0;
        end else if (state_q == GEN && state_d == DONE) begin
            blk_cnt_q <= blk_cnt_q + 32'd1;
        end
    end

    assign block_count = blk_cnt_q;
`endif

endmodule

// File: tb/tb_trivium_block_gen.sv
// Bench for trivium_block_gen: B=1/8/64 instances against a bit-level Trivium model.
// Scoreboard holds expected block and end_o arrival cycle per instance.
module tb_trivium_block_gen;

    localparam logic [79:0] K2 = 80'h0123456789ABCDEF0123;
    localparam logic [79:0] V2 = 80'hFEDCBA98765432100000;

    logic clk;
    logic rst;
    int   cyc;
    int   n_chk;
    int   n_fail;
    int   bval [3];
    logic prev_end [3];
    logic [63:0] exp_q [3][$];
    int          lat_q [3][$];

    trivium_block_gen_if if1 ();
    trivium_block_gen_if if8 ();
    trivium_block_gen_if if64 ();

`ifdef TRIVIUM_BLOCK_COUNT_EN
    logic [31:0] bc1, bc8, bc64;
`endif

    trivium_block_gen #(.BITS_PER_CYCLE(1)) u1 (
        .clk (clk),
        .rst (rst),
        .bus (if1)
`ifdef TRIVIUM_BLOCK_COUNT_EN
        ,
        .block_count (bc1)
`endif
    );

    trivium_block_gen #(.BITS_PER_CYCLE(8)) u8 (
        .clk (clk),
        .rst (rst),
        .bus (if8)
`ifdef TRIVIUM_BLOCK_COUNT_EN
        ,
        .block_count (bc8)
`endif
    );

    trivium_block_gen #(.BITS_PER_CYCLE(64)) u64 (
        .clk (clk),
        .rst (rst),
        .bus (if64)
`ifdef TRIVIUM_BLOCK_COUNT_EN
        ,
        .block_count (bc64)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model in 1-based state numbering; returns keystream block idx.
    function automatic logic [63:0] ks(
        input logic [79:0] k,
        input logic [79:0] v,
        input int idx
    );
        logic s [1:288];
        logic t1, t2, t3, z;
        logic [63:0] r;
        for (int i = 1; i <= 288; i++) s[i] = 1'b0;
        for (int i = 1; i <= 80; i++) begin
            s[i]      = k[80-i];
            s[93 + i] = v[80-i];
        end
        s[286] = 1'b1;
        s[287] = 1'b1;
        s[288] = 1'b1;
        r = '0;
        for (int n = 0; n < 1152 + 64 * (idx + 1); n++) begin
            t1 = s[66] ^ s[93];
            t2 = s[162] ^ s[177];
            t3 = s[243] ^ s[288];
            z  = t1 ^ t2 ^ t3;
            t1 = t1 ^ (s[91] & s[92]) ^ s[171];
            t2 = t2 ^ (s[175] & s[176]) ^ s[264];
            t3 = t3 ^ (s[286] & s[287]) ^ s[69];
            for (int j = 288; j > 178; j--) s[j] = s[j-1];
            s[178] = t2;
            for (int j = 177; j > 94; j--) s[j] = s[j-1];
            s[94] = t1;
            for (int j = 93; j > 1; j--) s[j] = s[j-1];
            s[1] = t3;
            if (n >= 1152 + 64 * idx) r = {r[62:0], z};
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input int k, input logic [63:0] b, input int lat);
        exp_q[k].push_back(b);
        lat_q[k].push_back(lat);
    endtask

    task automatic mon(input int k, input logic e, input logic [63:0] b);
        if (e === 1'b1 && prev_end[k] !== 1'b1) begin
            if (exp_q[k].size() == 0) begin
                chk($sformatf("spurious_end_b%0d", bval[k]), 64'(e), 64'd0);
            end else begin
                chk($sformatf("block_b%0d", bval[k]), b, exp_q[k].pop_front());
                chk($sformatf("end_cycle_b%0d", bval[k]), 64'(cyc), 64'(lat_q[k].pop_front()));
            end
        end
        prev_end[k] = e;
    endtask

    always @(negedge clk) begin
        mon(0, if1.end_o, if1.block_o);
        mon(1, if8.end_o, if8.block_o);
        mon(2, if64.end_o, if64.block_o);
    end

    task automatic wait_sb(input int max);
        int n;
        int pend;
        n = 0;
        pend = exp_q[0].size() + exp_q[1].size() + exp_q[2].size();
        while (pend != 0 && n < max) begin
            @(negedge clk);
            n++;
            pend = exp_q[0].size() + exp_q[1].size() + exp_q[2].size();
        end
        chk("scoreboard_drain", 64'(pend), 64'd0);
    endtask

    task automatic set_kv(input logic [79:0] k, input logic [79:0] v);
        if1.key = k;  if1.iv = v;
        if8.key = k;  if8.iv = v;
        if64.key = k; if64.iv = v;
    endtask

    task automatic set_next(input logic a, input logic b, input logic c);
        if1.next_block  = a;
        if8.next_block  = b;
        if64.next_block = c;
    endtask

    // Release at a negedge: two sync edges, then LOAD, then 1216/B step cycles.
    task automatic push_reload(input bit m1, input bit m8, input bit m64,
                               input logic [79:0] k, input logic [79:0] v, input int rel);
        logic [63:0] b0;
        b0 = ks(k, v, 0);
        if (m1)  push(0, b0, rel + 3 + 1216 / bval[0]);
        if (m8)  push(1, b0, rel + 3 + 1216 / bval[1]);
        if (m64) push(2, b0, rel + 3 + 1216 / bval[2]);
    endtask

    initial begin
        int rel;
        int c0;
        int n;
        logic [63:0] b0;
        logic [63:0] b1;
        bval[0] = 1;
        bval[1] = 8;
        bval[2] = 64;
        for (int k = 0; k < 3; k++) prev_end[k] = 1'b0;
        n_chk = 0;
        n_fail = 0;
        rst = 1'b0;
        set_kv('0, '0);
        set_next(1'b0, 1'b0, 1'b0);

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_end_b1", 64'(if1.end_o), 64'd0);
        chk("rst_blk_b1", if1.block_o, 64'd0);
        chk("rst_end_b8", 64'(if8.end_o), 64'd0);
        chk("rst_blk_b8", if8.block_o, 64'd0);
        chk("rst_end_b64", 64'(if64.end_o), 64'd0);
        chk("rst_blk_b64", if64.block_o, 64'd0);

        // All-zero key/iv on every width
        rel = cyc;
        rst = 1'b1;
        push_reload(1, 1, 1, '0, '0, rel);
        wait_sb(1400);

        // K2/V2, next_block held on B=1 through warm-up/gen, key/iv scrambled after LOAD
        rst = 1'b0;
        set_kv(K2, V2);
        if1.next_block = 1'b1;
        repeat (2) @(negedge clk);
        rel = cyc;
        rst = 1'b1;
        push_reload(1, 1, 1, K2, V2, rel);
        repeat (5) @(negedge clk);
        set_kv(80'hA5A5_5A5A_FFFF_0000_1234, 80'h0F0F_F0F0_DEAD_BEEF_CAFE);
        n = 0;
        while (if1.end_o !== 1'b1 && n < 1400) begin
            @(negedge clk);
            n++;
        end
        if1.next_block = 1'b0;
        chk("held_next_end_b1", 64'(if1.end_o), 64'd1);
        wait_sb(50);
        b0 = ks(K2, V2, 0);
        repeat (5) @(negedge clk);
        chk("hold_end_b1", 64'(if1.end_o), 64'd1);
        chk("hold_blk_b1", if1.block_o, b0);

        // One next_block pulse: end_o drops, old block held, then continuation
        b1 = ks(K2, V2, 1);
        c0 = cyc;
        set_next(1'b1, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) push(k, b1, c0 + 1 + 64 / bval[k]);
        @(negedge clk);
        set_next(1'b0, 1'b0, 1'b0);
        chk("next_end_low_b1", 64'(if1.end_o), 64'd0);
        chk("next_end_low_b8", 64'(if8.end_o), 64'd0);
        chk("next_old_blk_b1", if1.block_o, b0);
        chk("next_old_blk_b8", if8.block_o, b0);
        wait_sb(200);

        // Reset at warm-up edge 600 of B=1, then full rerun
        rst = 1'b0;
        set_kv(K2, V2);
        repeat (2) @(negedge clk);
        rel = cyc;
        rst = 1'b1;
        push_reload(0, 1, 1, K2, V2, rel);
        while (cyc < rel + 603) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_end_b1", 64'(if1.end_o), 64'd0);
        chk("midrst_blk_b1", if1.block_o, 64'd0);
        chk("midrst_end_b8", 64'(if8.end_o), 64'd0);
        chk("midrst_blk_b8", if8.block_o, 64'd0);
        repeat (3) @(negedge clk);
        rel = cyc;
        rst = 1'b1;
        push_reload(1, 1, 1, K2, V2, rel);
        wait_sb(1400);

`ifdef TRIVIUM_BLOCK_COUNT_EN
        chk("count_first", 64'(bc64), 64'd1);
        for (int j = 1; j <= 3; j++) begin
            c0 = cyc;
            if64.next_block = 1'b1;
            push(2, ks(K2, V2, j), c0 + 2);
            @(negedge clk);
            if64.next_block = 1'b0;
            wait_sb(20);
        end
        chk("count_four", 64'(bc64), 64'd4);
        force u64.blk_cnt_q = 32'hFFFF_FFFF;
        #1;
        release u64.blk_cnt_q;
        @(negedge clk);
        chk("count_preload", 64'(bc64), 64'hFFFF_FFFF);
        c0 = cyc;
        if64.next_block = 1'b1;
        push(2, ks(K2, V2, 4), c0 + 2);
        @(negedge clk);
        if64.next_block = 1'b0;
        wait_sb(20);
        chk("count_wrap", 64'(bc64), 64'd0);
        chk("count_b1", 64'(bc1), 64'd1);
`endif

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/trivium_block_gen.md
Name: trivium_block_gen

Overview:
- Unit under test for the autotest stage: loads key/iv, runs the Trivium warm-up, then collects keystream bits into a 64-bit block and raises end.
- Consumes the iv, key and UUT-reset signals driven by the test controller; produces end and block_o back to it.
- Optional next-block handshake produces further consecutive keystream blocks without a reload.

Parameters:
- BITS_PER_CYCLE, 1, cipher steps per clock; one of 1, 2, 4, 8, 16, 32 or 64 (divides both 64 and 1152).
- BLOCK_W, 64, output block width; fixed at 64 in this release.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset (driven from the controller's UUT reset).
- iv  in  80  initialisation vector; sampled only in LOAD.
- key  in  80  key; sampled only in LOAD.
- next_block  in  1  request for the following keystream block; honoured only in DONE; tie 0 if unused.
- end_o  out  1  block valid; level signal, held high while in DONE.
- block_o  out  64  keystream block; stable while end_o=1.

Behaviour:
- Reset (rst=0, async): state=LOAD, the 288-bit cipher state, step counter, block_o and end_o all 0. Release is synchronised internally with a 2-flop reset-release stage.
- State numbering: s1..s288. Key bit K1=key[79] ... K80=key[0]; IV1=iv[79] ... IV80=iv[0].
- LOAD, 1 cycle, captures key/iv:
  - s1..s93 = K1..K80 followed by 13 zeros.
  - s94..s177 = IV1..IV80 followed by 4 zeros.
  - s178..s288 = 108 zeros followed by 1,1,1.
  - Next state: WARMUP.
- One cipher step:
  - t1=s66^s93; t2=s162^s177; t3=s243^s288; z=t1^t2^t3.
  - t1^=(s91&s92)^s171; t2^=(s175&s176)^s264; t3^=(s286&s287)^s69.
  - Shift: s1..s93 <= t3,s1..s92; s94..s177 <= t1,s94..s176; s178..s288 <= t2,s178..s287.
- Each clock in WARMUP and GEN applies BITS_PER_CYCLE chained steps.
- WARMUP: 1152/BITS_PER_CYCLE cycles; z discarded; next state GEN.
- GEN: 64/BITS_PER_CYCLE cycles.
  - Each z bit shifts into a shadow register from the LSB side, so the first keystream bit ends at bit 63.
  - On the last GEN cycle the shadow register is copied to block_o; end_o rises on that same edge.
  - Next state: DONE.
- End latency: with cycle 0 being the first LOAD edge after synchronised release, end_o is 1 from edge 1+(1216/BITS_PER_CYCLE). That is edge 1217 for B=1 and edge 20 for B=64.
- DONE:
  - Cipher state is frozen; end_o=1; block_o is held.
  - next_block=1 causes the following edge to clear end_o and enter GEN; block_o keeps the old value until the new block completes.
  - The next block is the continuation of the keystream (no reload).
- next_block outside DONE: ignored, not queued.
- key/iv changes after LOAD: ignored.
- Step counter: 11 bits; wraps only through state changes, never free-runs.
- rst asserted mid-operation: immediate clear to reset values; a new LOAD follows release.

Optional Feature:
- Macro TRIVIUM_BLOCK_COUNT_EN.
- Defined: extra output block_count (out, 32): reset 0, incremented on every GEN->DONE transition, wraps 0xFFFFFFFF->0.
- Undefined: the port and counter are absent.

Decomposition:
- Package trivium_pkg:
  - STATE_W=288, KEY_W=80, IV_W=80, INIT_STEPS=1152.
  - Tap indices 66, 93, 91, 92, 171, 162, 177, 175, 176, 264, 243, 288, 286, 287, 69.
  - State enum {LOAD, WARMUP, GEN, DONE}.
- One sub-module, trivium_step: purely combinational, one step from state in to state out plus z. Instantiated BITS_PER_CYCLE times in a chain via generate.

Test Plan:
- key=0, iv=0, B=1, release reset -> end_o rises at edge 1217; block_o equals the golden C model's first 64 z bits, MSB first.
- Same vector with B=8 and B=64 -> end_o at edges 153 and 20; block_o identical to the B=1 result.
- key=80'h0123456789ABCDEF0123, iv=80'hFEDCBA98765432100000; in DONE pulse next_block once -> end_o low for 64/B cycles, then second block = model z bits 65..128; first block held meanwhile.
- next_block held high during WARMUP and GEN -> no effect; exactly one block until the first DONE.
- rst asserted at edge 600 of WARMUP, released 3 cycles later -> outputs 0 immediately; new end_o at 1217 edges after synchronised release with the same block value.
- TRIVIUM_BLOCK_COUNT_EN defined, 3 next_block requests -> block_count=4; preload 0xFFFFFFFF via force -> next block gives 0.
